// File: rtl/mood_light.sv
// mood_light - debounced mood register with ANGRY->HAPPY via NEUTRAL.
// Optional idle auto-return to NEUTRAL when MOOD_LIGHT_TIMEOUT_EN is defined.
module mood_light #(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned IDLE_TIMEOUT  = 16
) (
  input  logic [1:0] in,
  input  logic       reset,
  input  logic       clk,
  output logic [1:0] response
);

  typedef enum logic [1:0] {
    NEUTRAL = 2'b00,
    SAD     = 2'b01,
    HAPPY   = 2'b10,
    ANGRY   = 2'b11
  } mood_e;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [7:0] IDLE_MAX   = 8'(IDLE_TIMEOUT);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15 || IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_param
    $error("mood_light: parameter out of range");
  end

  mood_e      mood_q, mood_d;
  mood_e      cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic       same;
  logic       stable;
  logic       hold;

`ifdef MOOD_LIGHT_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
  logic       expired_q, expired_d;
`endif

  always_comb begin
    cand_d = mood_e'(in);
    same   = (cand_d == cand_q);
    if (same) begin
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd1;
    end
    stable = (cnt_d == STABLE_MAX);
    mood_d = mood_q;
`ifdef MOOD_LIGHT_TIMEOUT_EN
    idle_d    = idle_q;
    expired_d = expired_q && same;
    hold      = expired_d;
`else
    hold      = 1'b0;
`endif

    if (stable && (cand_d != mood_q) && !hold) begin
      // ANGRY may not jump straight to HAPPY; it calms down through NEUTRAL first.
      if (mood_q == ANGRY && cand_d == HAPPY) begin
        mood_d = NEUTRAL;
      end else begin
        mood_d = cand_d;
      end
    end

`ifdef MOOD_LIGHT_TIMEOUT_EN
    if (mood_d != mood_q) begin
      idle_d = 8'd0;
    end else if (mood_q != NEUTRAL) begin
      idle_d = same ? idle_q + 8'd1 : 8'd0;
      if (idle_d == IDLE_MAX) begin
        mood_d    = NEUTRAL;
        expired_d = 1'b1;
        idle_d    = 8'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mood_q <= NEUTRAL;
      cand_q <= NEUTRAL;
      cnt_q  <= 4'd0;
    end else begin
      mood_q <= mood_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef MOOD_LIGHT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= 8'd0;
      expired_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      expired_q <= expired_d;
    end
  end
`endif

  assign response = mood_q;

endmodule

// File: tb/tb_mood_light.sv
// tb/tb_mood_light.sv - directed-vector bench for mood_light (with or without MOOD_LIGHT_TIMEOUT_EN).
module tb_mood_light;

  logic       clk;
  logic       reset;
  logic [1:0] in1, in3;
  logic [1:0] resp1, resp3;
  int         n_vec;
  int         n_err;

  mood_light #(.STABLE_CYCLES(1), .IDLE_TIMEOUT(4)) u_dut1 (
    .in(in1), .reset(reset), .clk(clk), .response(resp1)
  );

  mood_light #(.STABLE_CYCLES(3)) u_dut3 (
    .in(in3), .reset(reset), .clk(clk), .response(resp3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq [4];
  logic [1:0] exp_v;

  initial begin
    n_vec = 0;
    n_err = 0;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b11;
    reset = 1'b1;
    in1   = 2'b11;
    in3   = 2'b00;

    #3 check_vec("rst_init", resp1, 2'b00);
    tick(); check_vec("rst_hold_a", resp1, 2'b00);
    tick(); check_vec("rst_hold_b", resp1, 2'b00);
    reset = 1'b0;
    tick(); check_vec("rel_first", resp1, 2'b11);
    check_vec("rel_dut3", resp3, 2'b00);

    foreach (seq[i]) begin
      in1 = seq[i];
      tick(); check_vec("seq1", resp1, seq[i]);
    end

    in1 = 2'b10;
    tick(); check_vec("angry_happy_a", resp1, 2'b00);
    tick(); check_vec("angry_happy_b", resp1, 2'b10);

    #2 reset = 1'b1;
    #1 check_vec("async_rst", resp1, 2'b00);
    in1 = 2'b11;
    tick(); check_vec("rst_edge", resp1, 2'b00);
    reset = 1'b0;
    tick(); check_vec("rst_rel2", resp1, 2'b11);

    in1 = 2'b10;
    tick(); check_vec("mid_ah_a", resp1, 2'b00);
    reset = 1'b1;
    #1 check_vec("mid_ah_rst", resp1, 2'b00);
    in1 = 2'b00;
    tick();
    reset = 1'b0;
    tick(); check_vec("mid_ah_abort_a", resp1, 2'b00);
    tick(); check_vec("mid_ah_abort_b", resp1, 2'b00);

    in1 = 2'b01;
    tick(); check_vec("idle_commit", resp1, 2'b01);
    for (int i = 0; i < 100; i++) begin
`ifdef MOOD_LIGHT_TIMEOUT_EN
      exp_v = (i < 3) ? 2'b01 : 2'b00;
`else
      exp_v = 2'b01;
`endif
      tick(); check_vec("idle_hold", resp1, exp_v);
    end
    in1 = 2'b11;
    tick(); check_vec("idle_new", resp1, 2'b11);

    in3 = 2'b01;
    tick(); check_vec("s3_short_a", resp3, 2'b00);
    tick(); check_vec("s3_short_b", resp3, 2'b00);
    in3 = 2'b00;
    tick(); check_vec("s3_short_c", resp3, 2'b00);
    in3 = 2'b01;
    tick(); check_vec("s3_full_a", resp3, 2'b00);
    tick(); check_vec("s3_full_b", resp3, 2'b00);
    tick(); check_vec("s3_full_c", resp3, 2'b01);
    in3 = 2'b00;
    tick(); check_vec("s3_glitch", resp3, 2'b01);
    in3 = 2'b10;
    tick(); check_vec("s3_happy_a", resp3, 2'b01);
    tick(); check_vec("s3_happy_b", resp3, 2'b01);
    tick(); check_vec("s3_happy_c", resp3, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
